// File: rtl/bp_update_arbiter.sv
// ---------------------------------------------------------------------------
// bp_update_arbiter
//
// Merges branch-resolution results from two commit-side requesters into the
// single update port of the 2-bit saturating branch predictor. Accepted
// results are held in a small in-order FIFO. The block drains one entry per
// enabled cycle onto registered update/update_pc/update_result outputs. The
// global rdy input pauses the whole block.
//
// Optional feature macro: BP_UPD_STATS_EN
//   When defined, the block adds the stat_accepted and stat_stall counters
//   as output ports.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   rdy            global enable (0 = pause; every register holds)
//   req0_*         commit slot 0 (older): valid, pc[31:0], taken, ready
//   req1_*         commit slot 1 (younger): valid, pc[31:0], taken, ready
//   update         registered update strobe to the predictor
//   update_pc      registered branch PC to the predictor
//   update_result  registered taken/not-taken to the predictor
//   fifo_count     current FIFO occupancy, 0..DEPTH
//   stat_accepted  (BP_UPD_STATS_EN) count of accepted requests, wraps
//   stat_stall     (BP_UPD_STATS_EN) count of rdy cycles with a stalled valid
// ---------------------------------------------------------------------------
module bp_update_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             req0_valid,
    input  logic [31:0]      req0_pc,
    input  logic             req0_taken,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_pc,
    input  logic             req1_taken,
    output logic             req1_ready,
    output logic             update,
    output logic [31:0]      update_pc,
    output logic             update_result,
    output logic [PTR_W:0]   fifo_count
`ifdef BP_UPD_STATS_EN
    ,
    output logic [15:0]      stat_accepted,
    output logic [15:0]      stat_stall
`endif
);

    localparam logic [PTR_W:0]   DEPTH_W  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Entry layout: {pc[31:0], taken}
    logic [32:0]      mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             update_q;
    logic [31:0]      update_pc_q;
    logic             update_result_q;

    logic [PTR_W:0]   free_s;
    logic             ready0_s;
    logic             ready1_s;
    logic             push0_s;
    logic             push1_s;
    logic             pop_s;
    logic [PTR_W:0]   n_push_s;
    logic [PTR_W-1:0] wr1_idx_s;

    // Readiness depends only on the registered count (and on req0_valid for
    // slot 1), so a same-cycle pop is never credited.
    always_comb begin
        free_s   = DEPTH_W - count_q;
        ready0_s = rdy && (free_s >= CNT_ONE);
        if (req0_valid) begin
            ready1_s = rdy && (free_s >= CNT_TWO);
        end else begin
            ready1_s = rdy && (free_s >= CNT_ONE);
        end
        push0_s = req0_valid && ready0_s;
        push1_s = req1_valid && ready1_s;
        pop_s   = rdy && (count_q != CNT_ZERO);
    end

    // Pointer/count next state; req1 lands behind req0 when both are accepted.
    always_comb begin
        n_push_s = (PTR_W+1)'(push0_s) + (PTR_W+1)'(push1_s);
        if (push0_s) begin
            wr1_idx_s = tail_q + PTR_ONE;
        end else begin
            wr1_idx_s = tail_q;
        end
        tail_d = tail_q + n_push_s[PTR_W-1:0];
        if (pop_s) begin
            head_d  = head_q + PTR_ONE;
            count_d = count_q + n_push_s - CNT_ONE;
        end else begin
            head_d  = head_q;
            count_d = count_q + n_push_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (push0_s) begin
            mem_q[tail_q] <= {req0_pc, req0_taken};
        end
        if (push1_s) begin
            mem_q[wr1_idx_s] <= {req1_pc, req1_taken};
        end
    end

    // Output registers: load head on pop, drop the strobe on an idle rdy
    // cycle, hold everything while paused so the predictor re-applies it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_q        <= 1'b0;
            update_pc_q     <= 32'h0000_0000;
            update_result_q <= 1'b0;
        end else if (pop_s) begin
            update_q        <= 1'b1;
            update_pc_q     <= mem_q[head_q][32:1];
            update_result_q <= mem_q[head_q][0];
        end else if (rdy) begin
            update_q        <= 1'b0;
        end
    end

    assign req0_ready    = ready0_s;
    assign req1_ready    = ready1_s;
    assign update        = update_q;
    assign update_pc     = update_pc_q;
    assign update_result = update_result_q;
    assign fifo_count    = count_q;

`ifdef BP_UPD_STATS_EN
    logic [15:0] stat_acc_q;
    logic [15:0] stat_stall_q;
    logic        stall_s;

    // A stall is any valid requester left unaccepted during an enabled cycle.
    always_comb begin
        stall_s = rdy && ((req0_valid && !ready0_s) || (req1_valid && !ready1_s));
    end

    // Free-running statistics counters, wrapping at 2^16.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_acc_q   <= 16'h0000;
            stat_stall_q <= 16'h0000;
        end else begin
            stat_acc_q <= stat_acc_q + 16'(n_push_s);
            if (stall_s) begin
                stat_stall_q <= stat_stall_q + 16'h0001;
            end
        end
    end

    assign stat_accepted = stat_acc_q;
    assign stat_stall    = stat_stall_q;
`endif

endmodule
